// File: rtl/simon_sequencer.sv
// simon_sequencer: Simon Says game engine that grows, plays back and checks a colour pattern.
// Ports: clock/reset (async active-low) | start begins or restarts a game |
//        new_num colour appended in ADD | btn_valid/btn_num debounced presses |
//        led_on/led_num playback drive | showing, awaiting_input, round_done,
//        level, game_over, game_won status.
// Optional build macro SIMON_TIMEOUT_EN: WAIT_IN loses after TIMEOUT_CYCLES idle cycles.
module simon_sequencer #(
    parameter int MAX_LEN        = 16,
    parameter int SHOW_CYCLES    = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [1:0]                   new_num,
    input  logic                         btn_valid,
    input  logic [1:0]                   btn_num,
    output logic                         led_on,
    output logic [1:0]                   led_num,
    output logic                         showing,
    output logic                         awaiting_input,
    output logic                         round_done,
    output logic [$clog2(MAX_LEN+1)-1:0] level,
    output logic                         game_over,
    output logic                         game_won
);
    localparam int LW   = $clog2(MAX_LEN + 1);
    localparam int IW   = $clog2(MAX_LEN);
    localparam int PMAX = SHOW_CYCLES > GAP_CYCLES ? SHOW_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(PMAX + 1);

    if (MAX_LEN < 2 || SHOW_CYCLES < 1 || GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1)
        $error("simon_sequencer: illegal parameter value");

    typedef enum logic [2:0] {IDLE, ADD, SHOW_ON, SHOW_GAP, WAIT_IN, LOSE, WON} state_t;

    state_t        state, state_n;
    logic [1:0]    mem [MAX_LEN];
    logic [IW-1:0] idx, idx_n;
    logic [LW-1:0] level_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          done_n, wr, last;
`ifdef SIMON_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt, tcnt_n;
`endif

    assign last = LW'(idx) == level - LW'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            level      <= '0;
            idx        <= '0;
            cnt        <= '0;
            round_done <= 1'b0;
        end else begin
            state      <= state_n;
            level      <= level_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            round_done <= done_n;
        end
    end

    // Pattern memory is deliberately left out of reset; it is always rewritten before it is read.
    always_ff @(posedge clock) begin
        if (wr) mem[level[IW-1:0]] <= new_num;
    end

`ifdef SIMON_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) tcnt <= '0;
        else        tcnt <= tcnt_n;
    end
`endif

    always_comb begin
        state_n = state;
        level_n = level;
        idx_n   = idx;
        cnt_n   = cnt;
        done_n  = 1'b0;
        wr      = 1'b0;
`ifdef SIMON_TIMEOUT_EN
        // Idle counter only runs while waiting with no press, so entry and every press clear it.
        tcnt_n  = (state == WAIT_IN && !btn_valid) ? tcnt + 1'b1 : '0;
`endif
        case (state)
            IDLE, LOSE, WON: begin
                if (start) begin
                    state_n = ADD;
                    level_n = '0;
                end
            end
            ADD: begin
                wr      = 1'b1;
                level_n = level + 1'b1;
                idx_n   = '0;
                cnt_n   = '0;
                state_n = SHOW_ON;
            end
            SHOW_ON: begin
                cnt_n   = cnt == CW'(SHOW_CYCLES - 1) ? '0 : cnt + 1'b1;
                state_n = cnt == CW'(SHOW_CYCLES - 1) ? SHOW_GAP : SHOW_ON;
            end
            SHOW_GAP: begin
                if (cnt == CW'(GAP_CYCLES - 1)) begin
                    cnt_n   = '0;
                    idx_n   = last ? '0 : idx + 1'b1;
                    state_n = last ? WAIT_IN : SHOW_ON;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_IN: begin
                if (btn_valid) begin
                    if (btn_num != mem[idx]) begin
                        state_n = LOSE;
                    end else if (last) begin
                        done_n  = 1'b1;
                        idx_n   = '0;
                        state_n = level == LW'(MAX_LEN) ? WON : ADD;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
`ifdef SIMON_TIMEOUT_EN
                else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_n = LOSE;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    assign led_on         = state == SHOW_ON;
    assign led_num        = led_on ? mem[idx] : 2'b0;
    assign showing        = state == SHOW_ON || state == SHOW_GAP;
    assign awaiting_input = state == WAIT_IN;
    assign game_over      = state == LOSE;
    assign game_won       = state == WON;
endmodule

// File: tb/tb_simon_sequencer.sv
// tb_simon_sequencer: randomized games checked cycle by cycle against a pattern-queue model.
module tb_simon_sequencer;
    localparam int ML = 4;
    localparam int SC = 4;
    localparam int GC = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       btn_valid = 1'b0;
    logic [1:0] new_num = 2'd0;
    logic [1:0] btn_num = 2'd0;
    logic       led_on, showing, awaiting_input, round_done, game_over, game_won;
    logic [1:0] led_num;
    logic [2:0] level;

    int n_checks = 0;
    int n_pass   = 0;
    int pat[$];

    always #5 clock = ~clock;

    simon_sequencer #(.MAX_LEN(ML), .SHOW_CYCLES(SC), .GAP_CYCLES(GC), .TIMEOUT_CYCLES(64)) dut (
        .clock(clock), .reset(reset), .start(start), .new_num(new_num),
        .btn_valid(btn_valid), .btn_num(btn_num), .led_on(led_on), .led_num(led_num),
        .showing(showing), .awaiting_input(awaiting_input), .round_done(round_done),
        .level(level), .game_over(game_over), .game_won(game_won)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic expect_out(input string tag, input int on, input int num, input int sh,
                              input int aw, input int rd, input int lv, input int go, input int gw);
        check({tag, ".led_on"}, led_on, on);
        check({tag, ".led_num"}, led_num, num);
        check({tag, ".showing"}, showing, sh);
        check({tag, ".awaiting_input"}, awaiting_input, aw);
        check({tag, ".round_done"}, round_done, rd);
        check({tag, ".level"}, level, lv);
        check({tag, ".game_over"}, game_over, go);
        check({tag, ".game_won"}, game_won, gw);
    endtask

    task automatic noise();
        btn_valid = $urandom_range(2) == 0;
        btn_num   = 2'($urandom_range(3));
        start     = $urandom_range(4) == 0;
        new_num   = 2'($urandom_range(3));
    endtask

    // Called at the negedge while the DUT sits in ADD; plays the grown pattern back.
    // A non-negative cut asserts reset at that playback cycle and abandons the round.
    task automatic add_round(input int from_round, input int cut);
        int c = $urandom_range(3);
        int t = 0;
        expect_out("add", 0, 0, 0, 0, from_round, pat.size(), 0, 0);
        new_num = 2'(c);
        pat.push_back(c);
        foreach (pat[i]) begin
            for (int k = 0; k < SC + GC; k++) begin
                @(negedge clock);
                expect_out("show", k < SC, k < SC ? pat[i] : 0, 1, 0, 0, pat.size(), 0, 0);
                if (t == cut) begin
                    start = 1'b0;
                    btn_valid = 1'b0;
                    reset = 1'b0;
                    #1;
                    expect_out("reset_async", 0, 0, 0, 0, 0, 0, 0, 0);
                    @(negedge clock);
                    expect_out("reset_held", 0, 0, 0, 0, 0, 0, 0, 0);
                    reset = 1'b1;
                    return;
                end
                t++;
                noise();
            end
        end
        @(negedge clock);
        btn_valid = 1'b0;
        start = 1'b0;
        expect_out("wait_entry", 0, 0, 0, 1, 0, pat.size(), 0, 0);
    endtask

    task automatic press(input int b);
        btn_valid = 1'b1;
        btn_num = 2'(b);
        @(negedge clock);
        btn_valid = 1'b0;
    endtask

    task automatic start_game();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        pat.delete();
        add_round(0, -1);
    endtask

    // res: 0 round cleared and next ADD reached, 1 lost, 2 won.
    task automatic play_round(input int wrong_at, output int res);
        res = 0;
        for (int i = 0; i < pat.size(); i++) begin
            repeat ($urandom_range(3)) begin
                btn_num = 2'($urandom_range(3));
                @(negedge clock);
                expect_out("wait_idle", 0, 0, 0, 1, 0, pat.size(), 0, 0);
            end
            if (i == wrong_at) begin
                press((pat[i] + 1 + $urandom_range(2)) % 4);
                expect_out("lose", 0, 0, 0, 0, 0, pat.size(), 1, 0);
                res = 1;
                return;
            end
            press(pat[i]);
            if (i < pat.size() - 1) begin
                expect_out("press_ok", 0, 0, 0, 1, 0, pat.size(), 0, 0);
            end else if (pat.size() == ML) begin
                expect_out("won", 0, 0, 0, 0, 1, ML, 0, 1);
                res = 2;
            end
        end
    endtask

    task automatic run_game(input int wrong_round, input int wrong_at);
        int res = 0;
        start_game();
        for (int r = 1; r <= ML; r++) begin
            play_round(r == wrong_round ? wrong_at : -1, res);
            if (res != 0) break;
            add_round(1, -1);
        end
        repeat (4) begin
            btn_valid = $urandom_range(1) == 1;
            btn_num = 2'($urandom_range(3));
            @(negedge clock);
            expect_out("post_game", 0, 0, 0, 0, 0, pat.size(), res == 1, res == 2);
        end
        btn_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int res;
        repeat (2) @(negedge clock);
        expect_out("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        @(negedge clock);
        btn_valid = 1'b1;
        btn_num = 2'd1;
        @(negedge clock);
        btn_valid = 1'b0;
        expect_out("idle", 0, 0, 0, 0, 0, 0, 0, 0);
        run_game(0, 0);
        run_game(2, 1);
        for (int g = 0; g < 6; g++) begin
            int wr = $urandom_range(ML);
            run_game(wr, wr == 0 ? 0 : $urandom_range(wr - 1));
        end
        start_game();
        play_round(-1, res);
        add_round(1, -1);
        play_round(-1, res);
        add_round(1, 2 * (SC + GC) + 1);
        btn_valid = 1'b1;
        @(negedge clock);
        btn_valid = 1'b0;
        expect_out("idle_after_reset", 0, 0, 0, 0, 0, 0, 0, 0);
        run_game(1, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/simon_sequencer.md
Name: simon_sequencer

Overview:
Game-sequence engine for Simon Says, and the consumer of the 2-bit colour index stream from the random-number generator. Appends one sampled colour per round to an internal pattern memory, plays the whole pattern back on the LED drive outputs, then checks player button presses against it. Sits between the colour source, the button debouncers and the LED/score display logic.

Parameters:
MAX_LEN, 16, pattern length at which the game is won (2..64)
SHOW_CYCLES, 4, clock cycles each colour is lit during playback (>=1)
GAP_CYCLES, 2, dark clock cycles after each lit colour (>=1)
TIMEOUT_CYCLES, 64, idle cycles allowed between presses (TIMEOUT_EN only)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
start  in  1  begin/restart game; sampled in IDLE, LOSE and WON only
new_num  in  2  colour index from generator, sampled in ADD
btn_valid  in  1  one-cycle pulse per debounced press
btn_num  in  2  colour of the press, valid with btn_valid
led_on  out  1  high while a colour is lit
led_num  out  2  colour being lit; 0 when led_on=0
showing  out  1  high in SHOW_ON/SHOW_GAP
awaiting_input  out  1  high in WAIT_IN
round_done  out  1  one-cycle pulse on correct completion of a round
level  out  $clog2(MAX_LEN+1)  current pattern length
game_over  out  1  held high in LOSE
game_won  out  1  held high in WON

Behaviour:
- Reset (async, reset=0): state IDLE, all outputs 0, level 0, idx 0, counters 0. Memory contents need not clear.
- IDLE: outputs 0. start=1 -> ADD, level<=0.
- ADD (1 cycle): mem[level]<=new_num, level<=level+1, idx<=0, phase counter<=0 -> SHOW_ON.
- SHOW_ON: led_on=1, led_num=mem[idx]; after exactly SHOW_CYCLES cycles -> SHOW_GAP.
- SHOW_GAP: led_on=0; after exactly GAP_CYCLES cycles: if idx==level-1 -> idx<=0, WAIT_IN; else idx<=idx+1 -> SHOW_ON.
- WAIT_IN: on btn_valid:
  - btn_num==mem[idx] and idx<level-1: idx<=idx+1.
  - btn_num==mem[idx] and idx==level-1: round_done pulses next cycle; if level==MAX_LEN -> WON, else -> ADD.
  - btn_num!=mem[idx]: -> LOSE.
- LOSE: game_over=1, level frozen; start=1 -> ADD with level<=0 (new game).
- WON: game_won=1, level=MAX_LEN; start=1 -> ADD with level<=0.
- btn_valid outside WAIT_IN ignored (no state or memory change). start ignored in ADD/SHOW/WAIT_IN.
- Latency: start edge -> ADD next cycle -> led_on high on the following cycle. Round playback length = level*(SHOW_CYCLES+GAP_CYCLES) cycles.
- level never exceeds MAX_LEN; idx never exceeds level-1. All outputs registered or decoded from registered state only.

Optional Feature:
SIMON_TIMEOUT_EN: defined -> WAIT_IN carries an idle counter cleared on entry and on every btn_valid; reaching TIMEOUT_CYCLES without a press -> LOSE (game_over=1). Undefined -> no counter, WAIT_IN waits indefinitely; TIMEOUT_CYCLES unused.

Test Plan:
- Assert reset=0 mid-SHOW_ON (level 3) -> all outputs 0 in same cycle, level 0, state IDLE after release.
- Defaults, start pulse with new_num=2 -> ADD, led_on=1/led_num=2 for 4 cycles, led_on=0 for 2, then awaiting_input=1, level=1.
- Round 1 mem={2}, new_num=1 at next ADD; press 2 -> round_done pulse, level=2, playback 2 (4 on, 2 off), 1 (4 on, 2 off), then awaiting_input.
- level 2 mem={2,1}, press 2 then 3 -> game_over=1, level stays 2, led_on=0; further btn_valid ignored; start -> level 1, new playback.
- MAX_LEN=4, four rounds all correct -> game_won=1 after 4th round_done, level=4; btn_valid ignored.
- SIMON_TIMEOUT_EN, TIMEOUT_CYCLES=8: in WAIT_IN, no press for 8 cycles -> game_over=1; press every 7 cycles -> no timeout.
